// File: rtl/dcp_pkg.sv
// Shared encodings and widths for the dehaze frame sequencer.
package dcp_pkg;

   localparam int unsigned CNT_W = 20;
   localparam int unsigned TO_W  = 24;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ALE_PASS,
      ST_ALE_WAIT,
      ST_TE_PASS,
      ST_TE_DRAIN
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE  = 2'b00,
      CAUSE_ALE   = 2'b01,
      CAUSE_FRAME = 2'b10,
      CAUSE_ERR   = 2'b11
   } cause_t;

endpackage

// File: rtl/dcp_beat_counter.sv
// Saturating up-counter with a flag that is high while the count equals TERM.
module dcp_beat_counter
   import dcp_pkg::*;
#(
   parameter int unsigned W    = CNT_W,
   parameter int unsigned TERM = 0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_term
);

   logic [W-1:0] r_cnt;

   // clear wins over increment so a terminal beat restarts from zero
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != '1)) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign o_term = (r_cnt == W'(TERM));

endmodule

// File: rtl/dcp_frame_sequencer.sv
// Sequences the ALE pass, the wait for atmospheric light, and the TE/SRSC pass of one frame.
module dcp_frame_sequencer
   import dcp_pkg::*;
#(
   parameter int unsigned IMG_W      = 512,
   parameter int unsigned IMG_H      = 512,
   parameter int unsigned OUT_PIXELS = IMG_W * IMG_H,
   parameter int unsigned TIMEOUT    = 2**20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       in_valid,
   input  logic       in_last,
   input  logic       ale_done,
   input  logic       out_valid,
   output logic       ale_enable,
   output logic       te_enable,
   output logic       out_last,
   output logic       busy,
   output logic       pass,
   output logic       intr,
   output logic [1:0] intr_cause,
   output logic       frame_err
);

   state_t r_state, w_next;
   cause_t r_cause, w_cause;
   logic   r_ale_en, r_te_en, r_busy, r_pass, r_intr, r_frame_err, r_ale_latch;
   logic   w_intr, w_err_set, w_start_go;
   logic   w_in_beat, w_out_beat, w_in_term, w_out_term, w_to_term, w_out_last;

   assign w_start_go = start & ~abort & (r_state == ST_IDLE);
   assign w_in_beat  = in_valid & ((r_state == ST_ALE_PASS) || (r_state == ST_TE_PASS));
   assign w_out_beat = out_valid & ((r_state == ST_TE_PASS) || (r_state == ST_TE_DRAIN));
   assign w_out_last = out_valid & r_te_en & w_out_term & ~rst;

   dcp_beat_counter #(.W(CNT_W), .TERM(IMG_W * IMG_H - 1)) u_in_cnt (
      .i_clk (clk),
      .i_rst (rst),
      .i_clr (w_start_go | (w_in_beat & w_in_term)),
      .i_inc (w_in_beat),
      .o_term(w_in_term)
   );

   dcp_beat_counter #(.W(CNT_W), .TERM(OUT_PIXELS - 1)) u_out_cnt (
      .i_clk (clk),
      .i_rst (rst),
      .i_clr (w_start_go),
      .i_inc (w_out_beat),
      .o_term(w_out_term)
   );

   // held at zero outside ALE_WAIT, so it measures cycles since entry
   dcp_beat_counter #(.W(TO_W), .TERM(TIMEOUT - 1)) u_to_cnt (
      .i_clk (clk),
      .i_rst (rst),
      .i_clr (r_state != ST_ALE_WAIT),
      .i_inc (1'b1),
      .o_term(w_to_term)
   );

   always_comb begin
      w_next    = r_state;
      w_intr    = 1'b0;
      w_cause   = CAUSE_NONE;
      w_err_set = w_in_beat & (in_last != w_in_term);
      case (r_state)
         ST_IDLE: begin
            if (start) w_next = ST_ALE_PASS;
         end
         ST_ALE_PASS: begin
            if (w_in_beat && w_in_term) w_next = ST_ALE_WAIT;
         end
         ST_ALE_WAIT: begin
            if (w_to_term) begin
               w_next    = ST_IDLE;
               w_intr    = 1'b1;
               w_cause   = CAUSE_ERR;
               w_err_set = 1'b1;
            end else if (ale_done || r_ale_latch) begin
               w_next  = ST_TE_PASS;
               w_intr  = 1'b1;
               w_cause = CAUSE_ALE;
            end
         end
         ST_TE_PASS: begin
            if (w_out_last) begin
               w_next  = ST_IDLE;
               w_intr  = 1'b1;
               w_cause = CAUSE_FRAME;
            end else if (w_in_beat && w_in_term) begin
               w_next = ST_TE_DRAIN;
            end
         end
         ST_TE_DRAIN: begin
            if (w_out_last) begin
               w_next  = ST_IDLE;
               w_intr  = 1'b1;
               w_cause = CAUSE_FRAME;
            end
         end
         default: w_next = ST_IDLE;
      endcase
      if (abort) begin
         w_next    = ST_IDLE;
         w_intr    = 1'b0;
         w_cause   = CAUSE_NONE;
         w_err_set = 1'b0;
      end
   end

   // registered outputs are decoded from the next state to give one-cycle latency
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_ale_en    <= 1'b0;
         r_te_en     <= 1'b0;
         r_busy      <= 1'b0;
         r_pass      <= 1'b0;
         r_intr      <= 1'b0;
         r_cause     <= CAUSE_NONE;
         r_frame_err <= 1'b0;
         r_ale_latch <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_ale_en <= (w_next == ST_ALE_PASS) || (w_next == ST_ALE_WAIT);
         r_te_en  <= (w_next == ST_TE_PASS) || (w_next == ST_TE_DRAIN);
         r_busy   <= (w_next != ST_IDLE);
         r_pass   <= (w_next == ST_TE_PASS) || (w_next == ST_TE_DRAIN);
         r_intr   <= w_intr;
         r_cause  <= w_cause;
         if (w_start_go) r_frame_err <= 1'b0;
         else if (w_err_set) r_frame_err <= 1'b1;
         if (w_start_go) r_ale_latch <= 1'b0;
         else if ((r_state != ST_IDLE) && ale_done) r_ale_latch <= 1'b1;
      end
   end

   assign ale_enable = r_ale_en;
   assign te_enable  = r_te_en;
   assign out_last   = w_out_last;
   assign busy       = r_busy;
   assign pass       = r_pass;
   assign intr       = r_intr;
   assign intr_cause = r_cause;
   assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_dcp_frame_sequencer.sv
// Directed frame scenarios with randomized beat spacing, checked against beat counts kept by the bench.
module tb_dcp_frame_sequencer;

   localparam int IMG_W      = 4;
   localparam int IMG_H      = 3;
   localparam int NPIX       = IMG_W * IMG_H;
   localparam int OUT_PIXELS = 12;
   localparam int TIMEOUT    = 16;

   logic       clk = 1'b0;
   logic       rst, start, abort, in_valid, in_last, ale_done, out_valid;
   logic       ale_enable, te_enable, out_last, busy, pass, intr, frame_err;
   logic [1:0] intr_cause;

   int n_err = 0;
   int n_chk = 0;
   int m_out = 0;
   int n_intr [4] = '{default: 0};
   int b_ale, b_frm, b_err, b_tot;

   dcp_frame_sequencer #(
      .IMG_W     (IMG_W),
      .IMG_H     (IMG_H),
      .OUT_PIXELS(OUT_PIXELS),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .ale_done  (ale_done),
      .out_valid (out_valid),
      .ale_enable(ale_enable),
      .te_enable (te_enable),
      .out_last  (out_last),
      .busy      (busy),
      .pass      (pass),
      .intr      (intr),
      .intr_cause(intr_cause),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (intr === 1'b1) n_intr[intr_cause] <= n_intr[intr_cause] + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run exceeded time limit, errors=%0d", n_err);
      $fatal(1, "watchdog expired");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkv(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic snap();
      b_ale = n_intr[1];
      b_frm = n_intr[2];
      b_err = n_intr[3];
      b_tot = n_intr[0] + n_intr[1] + n_intr[2] + n_intr[3];
   endtask

   task automatic begin_frame();
      snap();
      m_out = 0;
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   // input beats first..first+count-1 with random idle gaps; noise toggles out_valid/in_last in gaps
   task automatic feed(input int first, input int count, input logic [15:0] last_mask,
                       input int done_at, input logic noise);
      int gap;
      for (int i = first; i < first + count; i++) begin
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) begin
            in_valid  = 1'b0;
            in_last   = 1'($urandom_range(0, 1));
            out_valid = noise & 1'($urandom_range(0, 1));
            cyc();
         end
         in_valid  = 1'b1;
         in_last   = last_mask[i];
         ale_done  = (i == done_at);
         out_valid = 1'b0;
         cyc();
         in_valid = 1'b0;
         in_last  = 1'b0;
         ale_done = 1'b0;
      end
   endtask

   task automatic feed_out(input int n, input logic noise);
      int gap;
      for (int j = 0; j < n; j++) begin
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) begin
            out_valid = 1'b0;
            in_valid  = noise & 1'($urandom_range(0, 1));
            cyc();
         end
         out_valid = 1'b1;
         in_valid  = noise & 1'($urandom_range(0, 1));
         #1;
         chk("out_last_beat", out_last, m_out == OUT_PIXELS - 1);
         m_out++;
         @(posedge clk);
         #1;
         out_valid = 1'b0;
         in_valid  = 1'b0;
      end
   endtask

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
      in_last = 1'b0; ale_done = 1'b0; out_valid = 1'b0;
      cyc();
      cyc();
      chk("rst_ale_enable", ale_enable, 1'b0);
      chk("rst_te_enable", te_enable, 1'b0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_pass", pass, 1'b0);
      chk("rst_intr", intr, 1'b0);
      chkv("rst_cause", int'(intr_cause), 0);
      chk("rst_frame_err", frame_err, 1'b0);
      rst = 1'b0;

      // nominal frame
      begin_frame();
      chk("a_ale_enable", ale_enable, 1'b1);
      chk("a_busy", busy, 1'b1);
      chk("a_pass0", pass, 1'b0);
      chk("a_te_off", te_enable, 1'b0);
      feed(0, NPIX, 16'h0800, -1, 1'b1);
      chk("a_wait_ale_en", ale_enable, 1'b1);
      chk("a_wait_te_off", te_enable, 1'b0);
      repeat (4) cyc();
      chk("a_wait_no_intr", intr, 1'b0);
      ale_done = 1'b1;
      cyc();
      ale_done = 1'b0;
      chk("a_ale_intr", intr, 1'b1);
      chkv("a_ale_cause", int'(intr_cause), 1);
      chk("a_te_enable", te_enable, 1'b1);
      chk("a_ale_off", ale_enable, 1'b0);
      chk("a_pass1", pass, 1'b1);
      cyc();
      chk("a_intr_pulse", intr, 1'b0);
      feed(0, NPIX, 16'h0800, -1, 1'b0);
      chk("a_drain_te", te_enable, 1'b1);
      feed_out(OUT_PIXELS, 1'b1);
      chk("a_frame_intr", intr, 1'b1);
      chkv("a_frame_cause", int'(intr_cause), 2);
      chk("a_idle_busy", busy, 1'b0);
      chk("a_idle_te", te_enable, 1'b0);
      chk("a_no_err", frame_err, 1'b0);
      cyc();
      chk("a_frame_pulse", intr, 1'b0);
      chkv("a_cnt_ale", n_intr[1] - b_ale, 1);
      chkv("a_cnt_frm", n_intr[2] - b_frm, 1);

      // ale_done arrives during the ALE pass, then abort on the final output beat
      begin_frame();
      feed(0, NPIX, 16'h0800, 5, 1'b1);
      chk("b_entry_ale_en", ale_enable, 1'b1);
      chk("b_entry_no_intr", intr, 1'b0);
      cyc();
      chk("b_ale_intr", intr, 1'b1);
      chkv("b_ale_cause", int'(intr_cause), 1);
      chk("b_te_enable", te_enable, 1'b1);
      repeat (3) cyc();
      chkv("b_cnt_ale_once", n_intr[1] - b_ale, 1);
      feed_out(OUT_PIXELS - 1, 1'b0);
      abort = 1'b1;
      out_valid = 1'b1;
      #1;
      chk("b_abort_out_last", out_last, 1'b1);
      @(posedge clk);
      #1;
      abort = 1'b0;
      out_valid = 1'b0;
      chk("b_abort_busy", busy, 1'b0);
      chk("b_abort_te", te_enable, 1'b0);
      chk("b_abort_pass", pass, 1'b0);
      chk("b_abort_intr", intr, 1'b0);
      chk("b_abort_err", frame_err, 1'b0);
      repeat (2) cyc();
      chkv("b_cnt_total", n_intr[0] + n_intr[1] + n_intr[2] + n_intr[3] - b_tot, 1);

      // early TLAST on beat 7, start ignored during TE pass
      begin_frame();
      feed(0, 7, 16'h0840, -1, 1'b1);
      chk("c_early_tlast", frame_err, 1'b1);
      feed(7, NPIX - 7, 16'h0840, -1, 1'b1);
      ale_done = 1'b1;
      cyc();
      ale_done = 1'b0;
      chkv("c_ale_cause", int'(intr_cause), 1);
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("c_start_busy", busy, 1'b1);
      chk("c_start_pass", pass, 1'b1);
      chk("c_err_kept", frame_err, 1'b1);
      feed(0, NPIX, 16'h0800, -1, 1'b0);
      feed_out(OUT_PIXELS, 1'b1);
      chk("c_frame_intr", intr, 1'b1);
      chkv("c_frame_cause", int'(intr_cause), 2);
      chk("c_idle_busy", busy, 1'b0);
      chk("c_err_sticky", frame_err, 1'b1);
      cyc();
      chkv("c_cnt_err", n_intr[3] - b_err, 0);
      chkv("c_cnt_frm", n_intr[2] - b_frm, 1);

      // timeout in ALE_WAIT, with a start pulse mid ALE pass that must not restart counting
      begin_frame();
      chk("d_start_clears_err", frame_err, 1'b0);
      feed(0, 5, 16'h0800, -1, 1'b1);
      start = 1'b1;
      cyc();
      start = 1'b0;
      feed(5, NPIX - 5, 16'h0800, -1, 1'b1);
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         cyc();
         n++;
      end
      chkv("d_timeout_cycles", n, TIMEOUT);
      chk("d_to_intr", intr, 1'b1);
      chkv("d_to_cause", int'(intr_cause), 3);
      chk("d_to_err", frame_err, 1'b1);
      chk("d_to_ale_off", ale_enable, 1'b0);
      cyc();
      chk("d_to_pulse", intr, 1'b0);
      chkv("d_to_cause_clr", int'(intr_cause), 0);
      chk("d_err_held", frame_err, 1'b1);

      // missing TLAST on the last beat, then reset mid-frame
      begin_frame();
      chk("e_start_clears_err", frame_err, 1'b0);
      feed(0, NPIX - 1, 16'h0000, -1, 1'b1);
      chk("e_no_err_yet", frame_err, 1'b0);
      feed(NPIX - 1, 1, 16'h0000, -1, 1'b1);
      chk("e_late_tlast", frame_err, 1'b1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("e_rst_busy", busy, 1'b0);
      chk("e_rst_ale", ale_enable, 1'b0);
      chk("e_rst_err", frame_err, 1'b0);
      chk("e_rst_intr", intr, 1'b0);
      cyc();
      chkv("e_cnt_total", n_intr[0] + n_intr[1] + n_intr[2] + n_intr[3] - b_tot, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/dcp_frame_sequencer.md
DCP_FRAME_SEQUENCER -- requirements
Module: dcp_frame_sequencer

Interface
REQ-001 SHALL have parameter IMG_W, default 512: active pixels per line.
REQ-002 SHALL have parameter IMG_H, default 512: lines per frame.
REQ-003 SHALL have parameter OUT_PIXELS, default IMG_W*IMG_H: output beats expected from the TE/SRSC pass.
REQ-004 SHALL have parameter TIMEOUT, default 2**20: maximum cycles in ALE_WAIT.
REQ-005 SHALL have ports as follows. The block uses one clock; reset is synchronous and active-high.
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high.
- start  in  1  one-cycle request to process a frame.
- abort  in  1  forces a return to IDLE.
- in_valid  in  1  input pixel accepted (TVALID&TREADY).
- in_last  in  1  input TLAST, qualified by in_valid.
- ale_done  in  1  ALE has finished atmospheric-light estimation.
- out_valid  in  1  TE/SRSC output beat.
- ale_enable  out  1  gates the ALE clock.
- te_enable  out  1  gates the TE/SRSC clock.
- out_last  out  1  output TLAST.
- busy  out  1  high in any non-IDLE state.
- pass  out  1  0 = ALE pass, 1 = TE pass.
- intr  out  1  one-cycle interrupt pulse.
- intr_cause  out  2  01 = ALE done, 10 = frame done, 11 = error; 00 otherwise.
- frame_err  out  1  sticky error flag.

Function
REQ-006 SHALL implement the states IDLE, ALE_PASS, ALE_WAIT, TE_PASS and TE_DRAIN, held in a registered state register.
REQ-007 In IDLE, ale_enable, te_enable and busy SHALL be 0; start SHALL clear all counters, clear frame_err and go to ALE_PASS on the next cycle.
REQ-008 start SHALL be ignored outside IDLE.
REQ-009 In ALE_PASS, ale_enable SHALL be 1 and pass SHALL be 0; in_cnt (20-bit) SHALL increment on each in_valid.
REQ-010 When in_valid is high and in_cnt==IMG_W*IMG_H-1, the block SHALL go to ALE_WAIT and reset in_cnt to 0.
REQ-011 In_last asserted when in_cnt!=IMG_W*IMG_H-1 (early), or last beat without in_last (late), SHALL set frame_err; it SHALL NOT alter state transitions.
REQ-012 ale_done SHALL be latched in every non-IDLE state; the latch SHALL clear on start.
REQ-013 ALE_WAIT SHALL keep ale_enable at 1.
REQ-014 ALE_WAIT SHALL exit to TE_PASS when ale_done or the latch is set, same-cycle when it is already latched on entry.
- That transition SHALL pulse intr with intr_cause=01.
REQ-015 In ALE_WAIT, a 24-bit timeout counter SHALL count cycles.
- On reaching TIMEOUT-1, the block SHALL go to IDLE.
- It SHALL set frame_err and pulse intr with intr_cause=11.
REQ-016 In TE_PASS, te_enable SHALL be 1, ale_enable SHALL be 0 and pass SHALL be 1.
- in_cnt SHALL count in_valid as in ALE_PASS.
- On the last beat, the block SHALL go to TE_DRAIN.
REQ-017 In TE_PASS and TE_DRAIN, out_cnt (20-bit) SHALL increment on each out_valid.
REQ-018 out_last SHALL be combinational: out_valid & te_enable & (out_cnt==OUT_PIXELS-1).
REQ-019 The out_last beat SHALL move the block to IDLE with intr pulsed, intr_cause=10, in either TE_PASS or TE_DRAIN.
REQ-020 In TE_DRAIN, te_enable SHALL stay 1 and in_valid SHALL be ignored, with no count.
REQ-021 out_valid outside TE_PASS/TE_DRAIN SHALL NOT be counted.
REQ-022 abort SHALL have priority over all events: next state IDLE, enables 0 the next cycle, no intr, frame_err unchanged.
REQ-023 Only one intr pulse SHALL occur per cycle; the error cause (11) SHALL win over others.
REQ-024 Counters SHALL saturate and never wrap.
REQ-025 All outputs except out_last SHALL be registered, with one-cycle latency from the causing event.

Reset
REQ-026 rst SHALL force IDLE and zero all counters and the ale_done latch.
REQ-027 rst SHALL drive ale_enable, te_enable, out_last, busy, pass, intr, intr_cause and frame_err to 0.
REQ-028 rst asserted mid-frame SHALL abandon the frame with no intr.

Structure
REQ-029 The state encoding, intr_cause codes and counter widths SHALL reside in shared package dcp_pkg.
REQ-030 A single sub-module dcp_beat_counter SHALL provide the saturating count with terminal-match flag.
- It SHALL be instantiated for in_cnt and for out_cnt.

Verification
REQ-031 Run with IMG_W=4, IMG_H=3, OUT_PIXELS=12:
- Stimulus: start, then 12 in_valid beats, then ale_done 5 cycles later.
- Required response: intr with cause 01 one cycle after ale_done; te_enable=1.
REQ-032 Continue the REQ-031 run:
- Stimulus: 12 more in_valid beats, then 12 out_valid beats.
- Required response: out_last only on beat 12; intr cause 10; busy=0 the next cycle.
REQ-033 Early-done case:
- Stimulus: ale_done during beat 6 of ALE_PASS.
- Required response: ALE_WAIT exits on its entry cycle; cause 01 pulses once.
REQ-034 Timeout case:
- Stimulus: TIMEOUT=16, no ale_done.
- Required response: after 16 ALE_WAIT cycles, IDLE, frame_err=1, cause 11.
REQ-035 Early TLAST case:
- Stimulus: in_last on beat 7 of 12.
- Required response: frame_err=1; frame completes normally with cause 10.
REQ-036 Abort and start-ignore case:
- Stimulus: abort in TE_PASS with simultaneous out_valid, then start while busy.
- Required response: IDLE next cycle; no intr; start ignored while busy.
